// File: rtl/sys_types.sv
// Shared element and tile types for the systolic-array output path
// (requant, tile_emitter, maxpool).
package sys_types;
   typedef logic signed [7:0] int8_t;

   localparam int TILE_N = 4;
   typedef int8_t [TILE_N-1:0][TILE_N-1:0] tile_t;
endpackage

// File: rtl/tile_emitter_pkg.sv
// State encoding for the tile emitter drain FSM.
package tile_emitter_pkg;
   typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/tile_emitter.sv
// Captures one SA_N x SA_N int8 tile and drains it a row per cycle onto SA_N
// lanes, each tagged with its absolute coordinate and masked to the matrix.
module tile_emitter
   import sys_types::*;
   import tile_emitter_pkg::*;
#(
   parameter int SA_N   = 4,
   parameter int MAX_N  = 512,
   parameter int N_BITS = $clog2(MAX_N+1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             tile_valid,
   output logic                             tile_ready,
   input  int8_t [SA_N-1:0][SA_N-1:0]       tile_data,
   input  logic [N_BITS-1:0]                tile_row,
   input  logic [N_BITS-1:0]                tile_col,
   input  logic [N_BITS-1:0]                mat_rows,
   input  logic [N_BITS-1:0]                mat_cols,
   input  logic                             out_stall,
   output logic [SA_N-1:0]                  out_valid,
   output logic [SA_N-1:0][N_BITS-1:0]      out_row,
   output logic [SA_N-1:0][N_BITS-1:0]      out_col,
   output int8_t [SA_N-1:0]                 out_data,
   output logic [N_BITS-1:0]                pos_row,
   output logic [N_BITS-1:0]                pos_col,
   output logic                             tile_done
);
   localparam int CW = N_BITS + 1;
   localparam int RW = $clog2(SA_N);

   state_t                         state, state_nx;
   logic [RW-1:0]                  row_cnt;
   int8_t [SA_N-1:0][SA_N-1:0]     data_q;
   logic [N_BITS-1:0]              base_row_q, base_col_q, mat_rows_q, mat_cols_q;
   logic                           last_row, emit, capture;
   logic [CW-1:0]                  row_abs;
   logic [SA_N-1:0][CW-1:0]        col_abs;
   logic [SA_N-1:0]                lane_vld;

   assign last_row = (row_cnt == RW'(SA_N-1));
   assign emit     = (state == DRAIN) && !out_stall;
   assign capture  = tile_valid && tile_ready;

   always_comb begin
      tile_ready = 1'b0;
      state_nx   = state;
      case (state)
         IDLE: begin
            tile_ready = 1'b1;
            if (tile_valid) state_nx = DRAIN;
         end
         DRAIN: begin
            // Accepting on the last-row edge lets the next tile follow with no bubble.
            if (emit && last_row) begin
               tile_ready = 1'b1;
               state_nx   = tile_valid ? DRAIN : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // One extra bit so coordinates past 2^N_BITS still compare as out of bounds.
   assign row_abs = CW'(base_row_q) + CW'(row_cnt);

   for (genvar ch = 0; ch < SA_N; ch++) begin : g_lane
      assign col_abs[ch]  = CW'(base_col_q) + CW'(ch);
      assign lane_vld[ch] = (row_abs < CW'(mat_rows_q)) && (col_abs[ch] < CW'(mat_cols_q));
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         data_q     <= tile_data;
         base_row_q <= tile_row;
         base_col_q <= tile_col;
         mat_rows_q <= mat_rows;
         mat_cols_q <= mat_cols;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         row_cnt   <= '0;
         out_valid <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_data  <= '0;
         pos_row   <= '0;
         pos_col   <= '0;
         tile_done <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= emit ? lane_vld : '0;
         tile_done <= emit && last_row;
         if (capture)   row_cnt <= '0;
         else if (emit) row_cnt <= row_cnt + 1'b1;
         if (emit) begin
            out_data <= data_q[row_cnt];
            for (int ch = 0; ch < SA_N; ch++) begin
               out_row[ch] <= row_abs[N_BITS-1:0];
               out_col[ch] <= col_abs[ch][N_BITS-1:0];
            end
            if (row_cnt == '0) begin
               pos_row <= base_row_q;
               pos_col <= base_col_q;
            end
         end
      end
   end
endmodule

// File: doc/tile_emitter.md
Name: tile_emitter

Overview:
- Transmit side of the per-column pooling/requant lane interface: valid, row, col and data per systolic-array column.
- Accepts one completed SA_N x SA_N tile of requantized int8 results with its base coordinate, then drains it one row per cycle onto SA_N lanes.
- Each lane carries its absolute matrix coordinate and a base position for the downstream pooling stage.
- Sits between the requant units and maxpool_unit; masks lanes that fall outside the matrix bounds.

Parameters:
- SA_N, 4, tile dimension / number of output lanes (power of 2, >=2)
- MAX_N, 512, maximum matrix dimension
- N_BITS, $clog2(MAX_N+1), width of coordinates and matrix sizes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tile_valid  in  1  tile offered by upstream
- tile_ready  out  1  block can capture a tile this cycle
- tile_data  in  int8_t [SA_N][SA_N]  tile, indexed [row][col]
- tile_row  in  N_BITS  absolute row of tile element [0][0]
- tile_col  in  N_BITS  absolute column of tile element [0][0]
- mat_rows  in  N_BITS  matrix height; rows >= mat_rows are masked
- mat_cols  in  N_BITS  matrix width; cols >= mat_cols are masked
- out_stall  in  1  downstream cannot accept a row this cycle
- out_valid  out  1 x [SA_N]  lane valid
- out_row  out  N_BITS x [SA_N]  absolute row of lane sample
- out_col  out  N_BITS x [SA_N]  absolute column of lane sample
- out_data  out  int8_t x [SA_N]  lane sample
- pos_row  out  N_BITS  base row of tile currently draining
- pos_col  out  N_BITS  base column of tile currently draining
- tile_done  out  1  one-cycle pulse with the last row of a tile

Behaviour:
- Reset: state IDLE, row counter 0, tile buffer contents don't-care. All out_valid, tile_done, out_row/out_col/out_data, pos_row/pos_col are 0. A reset mid-drain discards the tile; no further lanes are emitted.
- State IDLE:
  - tile_ready=1.
  - On tile_valid: capture tile_data, tile_row, tile_col, mat_rows, mat_cols into internal registers; row_cnt<=0; go to DRAIN.
  - No outputs are valid in IDLE.
- State DRAIN:
  - Each non-stalled cycle, register row row_cnt to the outputs: lane ch gets data[row_cnt][ch], out_row=base_row+row_cnt, out_col=base_col+ch.
  - Valid rule: out_valid[ch]=1 iff (base_row+row_cnt)<mat_rows_q and (base_col+ch)<mat_cols_q.
  - Comparisons use N_BITS+1 bits; coordinates are output truncated to N_BITS.
  - Fully masked rows still consume one cycle.
- Stall: while out_stall=1, next-cycle out_valid are all 0, tile_done=0, and row_cnt holds. Coordinate/data outputs may hold. No row is ever skipped or duplicated.
- Latency: a tile captured on edge T gives row 0 at T+1 and row r at T+1+r if there is no stall.
- Last row: when row_cnt==SA_N-1 and not stalled, register the last row and pulse tile_done with it.
  - tile_ready=1 in that cycle. If tile_valid=1, the next tile is captured on the same edge and its row 0 appears the following cycle (gapless back-to-back).
  - Otherwise go to IDLE.
- tile_ready is combinational from state, row_cnt and out_stall. It never depends on tile_valid.
- pos_row/pos_col update when a tile's row 0 is registered and hold until the next tile's row 0.
- Upstream must hold tile_data stable while tile_valid=1 and tile_ready=0.

Decomposition:
- int8_t comes from the shared sys_types package. Add a tile typedef (int8_t [SA_N][SA_N]) there for reuse by requant and maxpool.
- No sub-module: a single FSM plus row counter plus lane mask generator. Lane masking is a generate loop, not a separate module.

Test Plan:
- SA_N=4: tile 4x4, data[r][c]=r*4+c, base (8,12), mat 32x32 -> cycles T+1..T+4 emit all lanes valid, row 8..11, col 12..15, data matches; tile_done only at T+4; pos=(8,12).
- Edge clip: base (28,30), mat 30x31 -> rows 28,29 have lane0 valid only (col 30); rows 30,31 emit all lanes invalid; still 4 cycles, tile_done on the 4th.
- Stall: out_stall=1 during cycles T+2,T+3 -> those cycles have all lanes invalid; rows 1..3 appear at T+4..T+6; no duplicates; tile_done at T+6.
- Back-to-back: tile_valid held high with two tiles -> tile_ready high only in IDLE and on the last-row cycle; 8 consecutive valid rows, no bubble; pos switches on the 5th row.
- Stall on last row: out_stall=1 while row_cnt=3 -> tile_ready=0; the pending tile is not captured until the stall drops.
- Reset mid-drain after row 1 -> all outputs 0 next cycle; IDLE with tile_ready=1; the following tile drains correctly from row 0.
